// File: rtl/l2_port_arbiter_if.sv
// L1-to-L2 miss-path bundle shared by the I-cache, the D-cache, the L2 port and the arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding L1/L2 environment.
interface l2_port_arbiter_if #(
    parameter int TNUM = 21,
    parameter int INUM = 26 - TNUM,
    parameter int LINE = 512
);
    logic            read_I_arb;
    logic [TNUM-1:0] tag_I_arb;
    logic [INUM-1:0] index_I_arb;
    logic            ready_arb_I;
    logic [LINE-1:0] read_data_arb_I;
    logic            read_D_arb;
    logic            write_D_arb;
    logic [TNUM-1:0] tag_D_arb;
    logic [INUM-1:0] index_D_arb;
    logic [LINE-1:0] write_data_D_arb;
    logic            ready_arb_D;
    logic [LINE-1:0] read_data_arb_D;
    logic            read_arb_L2;
    logic            write_arb_L2;
    logic [TNUM-1:0] tag_arb_L2;
    logic [INUM-1:0] index_arb_L2;
    logic [LINE-1:0] write_data_arb_L2;
    logic            ready_L2_arb;
    logic [LINE-1:0] read_data_L2_arb;
    logic [1:0]      grant;

    modport slave (
        input  read_I_arb, tag_I_arb, index_I_arb,
        input  read_D_arb, write_D_arb, tag_D_arb, index_D_arb, write_data_D_arb,
        input  ready_L2_arb, read_data_L2_arb,
        output ready_arb_I, read_data_arb_I, ready_arb_D, read_data_arb_D,
        output read_arb_L2, write_arb_L2, tag_arb_L2, index_arb_L2, write_data_arb_L2,
        output grant
    );

    modport master (
        output read_I_arb, tag_I_arb, index_I_arb,
        output read_D_arb, write_D_arb, tag_D_arb, index_D_arb, write_data_D_arb,
        output ready_L2_arb, read_data_L2_arb,
        input  ready_arb_I, read_data_arb_I, ready_arb_D, read_data_arb_D,
        input  read_arb_L2, write_arb_L2, tag_arb_L2, index_arb_L2, write_data_arb_L2,
        input  grant
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 request port between the I-cache and D-cache miss paths.
// The winner's request is registered onto the L2 port. The L2 ready pulse is steered back to that winner only.
module l2_port_arbiter #(
    parameter int TNUM = 21,
    parameter int INUM = 26 - TNUM,
    parameter int LINE = 512
) (
    input logic               clk,
    input logic               rst,
    l2_port_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    logic [1:0]      state_r;
    logic            last_d_r;
    logic [1:0]      grant_r;
    logic            read_r;
    logic            write_r;
    logic [TNUM-1:0] tag_r;
    logic [INUM-1:0] index_r;
    logic [LINE-1:0] wdata_r;

    logic            req_i_s;
    logic            req_d_s;
    logic            pick_d_s;
    logic            done_s;

    assign req_i_s = bus.read_I_arb;
    assign req_d_s = bus.read_D_arb | bus.write_D_arb;

    // An L2 completion counts only while a transaction is actually outstanding.
    assign done_s  = (state_r == ST_BUSY) & bus.ready_L2_arb & ~rst;

    // Winner selection: a lone requester wins; on a tie, the side that did not win last time wins.
    always_comb begin
        pick_d_s = 1'b0;
        if (req_i_s && req_d_s) begin
            pick_d_s = ~last_d_r;
        end else if (req_d_s) begin
            pick_d_s = 1'b1;
        end else begin
            pick_d_s = 1'b0;
        end
    end

    // Arbitration FSM and the registered L2 request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            last_d_r <= 1'b1;
            grant_r  <= GNT_NONE;
            read_r   <= 1'b0;
            write_r  <= 1'b0;
            tag_r    <= '0;
            index_r  <= '0;
            wdata_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_i_s || req_d_s) begin
                        state_r <= ST_BUSY;
                        if (pick_d_s) begin
                            // A pending write-back goes first; the refill re-arbitrates later.
                            grant_r  <= GNT_D;
                            last_d_r <= 1'b1;
                            write_r  <= bus.write_D_arb;
                            read_r   <= ~bus.write_D_arb;
                            tag_r    <= bus.tag_D_arb;
                            index_r  <= bus.index_D_arb;
                            wdata_r  <= bus.write_data_D_arb;
                        end else begin
                            grant_r  <= GNT_I;
                            last_d_r <= 1'b0;
                            write_r  <= 1'b0;
                            read_r   <= 1'b1;
                            tag_r    <= bus.tag_I_arb;
                            index_r  <= bus.index_I_arb;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.ready_L2_arb) begin
                        state_r <= ST_RELEASE;
                        grant_r <= GNT_NONE;
                        read_r  <= 1'b0;
                        write_r <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= GNT_NONE;
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant             = grant_r;
    assign bus.read_arb_L2       = read_r;
    assign bus.write_arb_L2      = write_r;
    assign bus.tag_arb_L2        = tag_r;
    assign bus.index_arb_L2      = index_r;
    assign bus.write_data_arb_L2 = wdata_r;

    assign bus.ready_arb_I     = done_s & (grant_r == GNT_I);
    assign bus.ready_arb_D     = done_s & (grant_r == GNT_D);
    assign bus.read_data_arb_I = bus.read_data_L2_arb;
    assign bus.read_data_arb_D = bus.read_data_L2_arb;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed corner sequences, an arbitration vector table,
// and a randomized run checked against a transaction-level reference model.
module tb_l2_port_arbiter;
    localparam int TNUM = 21;
    localparam int INUM = 5;
    localparam int LINE = 512;
    typedef logic [LINE-1:0] word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_port_arbiter_if #(.TNUM(TNUM), .INUM(INUM), .LINE(LINE)) bus ();
    l2_port_arbiter #(.TNUM(TNUM), .INUM(INUM), .LINE(LINE)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.read_I_arb       = 1'b0;
        bus.tag_I_arb        = '0;
        bus.index_I_arb      = '0;
        bus.read_D_arb       = 1'b0;
        bus.write_D_arb      = 1'b0;
        bus.tag_D_arb        = '0;
        bus.index_D_arb      = '0;
        bus.write_data_D_arb = '0;
        bus.ready_L2_arb     = 1'b0;
        bus.read_data_L2_arb = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic no_ready(input string name);
        chk({name, "_rdyI"}, word_t'(bus.ready_arb_I), word_t'(1'b0));
        chk({name, "_rdyD"}, word_t'(bus.ready_arb_D), word_t'(1'b0));
    endtask

    typedef struct {
        bit         rd_i;
        bit         rd_d;
        bit         wr_d;
        logic [1:0] g;
        bit         r;
        bit         w;
    } vec_t;
    vec_t tbl[8];

    // reference model state (transaction level)
    bit              m_busy;
    bit              m_cool;
    int              m_who;
    int              m_last;
    bit              m_wr;
    logic [TNUM-1:0] m_tag;
    logic [INUM-1:0] m_idx;
    word_t           m_wdata;

    initial begin
        logic [31:0] r32;
        word_t       dat;
        bit          i_rd, d_rd, d_wr, e_rdy_i, e_rdy_d;
        logic [1:0]  e_g;

        // 1: reset, with an L2 ready pulse that must not reach either L1
        rst = 1'b1;
        clear_inputs();
        tick();
        bus.ready_L2_arb = 1'b1;
        settle();
        no_ready("rst_pulse");
        tick();
        tick();
        chk("rst_grant", word_t'(bus.grant), word_t'(2'b00));
        chk("rst_read",  word_t'(bus.read_arb_L2), word_t'(1'b0));
        chk("rst_write", word_t'(bus.write_arb_L2), word_t'(1'b0));
        chk("rst_tag",   word_t'(bus.tag_arb_L2), word_t'(0));
        chk("rst_idx",   word_t'(bus.index_arb_L2), word_t'(0));
        chk("rst_wdata", bus.write_data_arb_L2, word_t'(0));
        rst = 1'b0;
        bus.ready_L2_arb = 1'b0;

        // 2: lone I refill
        bus.read_I_arb  = 1'b1;
        bus.tag_I_arb   = 21'h1ABCD;
        bus.index_I_arb = 5'd5;
        tick();
        chk("i_read",  word_t'(bus.read_arb_L2), word_t'(1'b1));
        chk("i_write", word_t'(bus.write_arb_L2), word_t'(1'b0));
        chk("i_tag",   word_t'(bus.tag_arb_L2), word_t'(21'h1ABCD));
        chk("i_idx",   word_t'(bus.index_arb_L2), word_t'(5'd5));
        chk("i_grant", word_t'(bus.grant), word_t'(2'b01));
        tick();
        tick();
        tick();
        bus.ready_L2_arb     = 1'b1;
        bus.read_data_L2_arb = {16{32'hDEADBEEF}};
        settle();
        chk("i_rdyI", word_t'(bus.ready_arb_I), word_t'(1'b1));
        chk("i_data", bus.read_data_arb_I, {16{32'hDEADBEEF}});
        chk("i_rdyD", word_t'(bus.ready_arb_D), word_t'(1'b0));
        tick();
        bus.ready_L2_arb = 1'b0;
        bus.read_I_arb   = 1'b0;
        settle();
        chk("i_pulse_end", word_t'(bus.ready_arb_I), word_t'(1'b0));
        chk("i_read_off",  word_t'(bus.read_arb_L2), word_t'(1'b0));
        chk("i_grant_off", word_t'(bus.grant), word_t'(2'b00));
        tick();

        // 3: simultaneous requests from reset, then alternation
        do_reset();
        bus.read_I_arb = 1'b1;
        bus.tag_I_arb  = 21'h00111;
        bus.read_D_arb = 1'b1;
        bus.tag_D_arb  = 21'h00222;
        tick();
        chk("rr_g0", word_t'(bus.grant), word_t'(2'b01));
        bus.ready_L2_arb = 1'b1;
        tick();
        bus.ready_L2_arb = 1'b0;
        bus.read_I_arb   = 1'b0;
        chk("rr_g1", word_t'(bus.grant), word_t'(2'b00));
        tick();
        chk("rr_g2", word_t'(bus.grant), word_t'(2'b00));
        bus.read_I_arb = 1'b1;
        tick();
        chk("rr_g3", word_t'(bus.grant), word_t'(2'b10));
        chk("rr_tagD", word_t'(bus.tag_arb_L2), word_t'(21'h00222));
        bus.ready_L2_arb = 1'b1;
        tick();
        bus.ready_L2_arb = 1'b0;
        bus.read_D_arb   = 1'b0;
        tick();
        tick();
        chk("rr_g4", word_t'(bus.grant), word_t'(2'b01));
        bus.ready_L2_arb = 1'b1;
        tick();
        bus.ready_L2_arb = 1'b0;
        bus.read_I_arb   = 1'b0;
        tick();

        // 4: D write-back ahead of its refill
        bus.read_D_arb       = 1'b1;
        bus.write_D_arb      = 1'b1;
        bus.tag_D_arb        = 21'h0F0F0;
        bus.index_D_arb      = 5'd9;
        bus.write_data_D_arb = {64{8'h5A}};
        tick();
        chk("wb_write", word_t'(bus.write_arb_L2), word_t'(1'b1));
        chk("wb_read",  word_t'(bus.read_arb_L2), word_t'(1'b0));
        chk("wb_data",  bus.write_data_arb_L2, {64{8'h5A}});
        chk("wb_grant", word_t'(bus.grant), word_t'(2'b10));
        bus.ready_L2_arb = 1'b1;
        settle();
        chk("wb_rdyD", word_t'(bus.ready_arb_D), word_t'(1'b1));
        chk("wb_rdyI", word_t'(bus.ready_arb_I), word_t'(1'b0));
        tick();
        bus.ready_L2_arb = 1'b0;
        bus.write_D_arb  = 1'b0;
        tick();
        tick();
        chk("rf_read",  word_t'(bus.read_arb_L2), word_t'(1'b1));
        chk("rf_write", word_t'(bus.write_arb_L2), word_t'(1'b0));
        chk("rf_tag",   word_t'(bus.tag_arb_L2), word_t'(21'h0F0F0));
        chk("rf_idx",   word_t'(bus.index_arb_L2), word_t'(5'd9));
        bus.ready_L2_arb = 1'b1;
        settle();
        chk("rf_rdyD", word_t'(bus.ready_arb_D), word_t'(1'b1));
        tick();
        bus.ready_L2_arb = 1'b0;
        bus.read_D_arb   = 1'b0;
        tick();

        // 5: inputs ignored while busy; stray L2 ready in RELEASE and IDLE
        bus.read_D_arb  = 1'b1;
        bus.tag_D_arb   = 21'h0AAAA;
        bus.index_D_arb = 5'd3;
        tick();
        bus.tag_D_arb   = 21'h15555;
        bus.index_D_arb = 5'd7;
        tick();
        tick();
        chk("hold_tag", word_t'(bus.tag_arb_L2), word_t'(21'h0AAAA));
        chk("hold_idx", word_t'(bus.index_arb_L2), word_t'(5'd3));
        bus.ready_L2_arb = 1'b1;
        tick();
        bus.read_D_arb = 1'b0;
        settle();
        no_ready("stray_rel");
        tick();
        settle();
        no_ready("stray_idle");
        tick();
        bus.ready_L2_arb = 1'b0;
        chk("stray_grant", word_t'(bus.grant), word_t'(2'b00));
        chk("stray_read",  word_t'(bus.read_arb_L2), word_t'(1'b0));

        // 6: reset in the middle of a transaction
        bus.read_D_arb = 1'b1;
        tick();
        bus.read_D_arb = 1'b0;
        chk("mid_busy", word_t'(bus.read_arb_L2), word_t'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_read",  word_t'(bus.read_arb_L2), word_t'(1'b0));
        chk("mid_grant", word_t'(bus.grant), word_t'(2'b00));
        bus.ready_L2_arb = 1'b1;
        settle();
        no_ready("mid_stale");
        tick();
        bus.ready_L2_arb = 1'b0;
        bus.read_I_arb   = 1'b1;
        bus.read_D_arb   = 1'b1;
        tick();
        chk("mid_regrant", word_t'(bus.grant), word_t'(2'b01));

        // arbitration table: each row is one full transaction starting from IDLE
        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};
        do_reset();
        bus.tag_I_arb = 21'h11111;
        bus.tag_D_arb = 21'h0DDDD;
        for (int v = 0; v < 8; v++) begin
            bus.read_I_arb  = tbl[v].rd_i;
            bus.read_D_arb  = tbl[v].rd_d;
            bus.write_D_arb = tbl[v].wr_d;
            tick();
            chk($sformatf("tbl%0d_grant", v), word_t'(bus.grant), word_t'(tbl[v].g));
            chk($sformatf("tbl%0d_read", v), word_t'(bus.read_arb_L2), word_t'(tbl[v].r));
            chk($sformatf("tbl%0d_write", v), word_t'(bus.write_arb_L2), word_t'(tbl[v].w));
            chk($sformatf("tbl%0d_tag", v), word_t'(bus.tag_arb_L2),
                word_t'((tbl[v].g == 2'b01) ? 21'h11111 : 21'h0DDDD));
            tick();
            bus.ready_L2_arb = 1'b1;
            settle();
            chk($sformatf("tbl%0d_rdyI", v), word_t'(bus.ready_arb_I), word_t'(tbl[v].g == 2'b01));
            chk($sformatf("tbl%0d_rdyD", v), word_t'(bus.ready_arb_D), word_t'(tbl[v].g == 2'b10));
            tick();
            bus.ready_L2_arb = 1'b0;
            bus.read_I_arb   = 1'b0;
            bus.read_D_arb   = 1'b0;
            bus.write_D_arb  = 1'b0;
            tick();
        end

        // randomized traffic against the reference model
        do_reset();
        m_busy = 1'b0;
        m_cool = 1'b0;
        m_last = 2;
        m_who  = 0;
        m_wr   = 1'b0;
        m_tag  = '0;
        m_idx  = '0;
        m_wdata = '0;
        i_rd = 1'b0;
        d_rd = 1'b0;
        d_wr = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!i_rd && $urandom_range(0, 2) == 0) begin
                i_rd = 1'b1;
                r32 = $urandom;
                bus.tag_I_arb   = r32[TNUM-1:0];
                bus.index_I_arb = r32[31:27];
            end
            if (!d_rd && !d_wr && $urandom_range(0, 2) == 0) begin
                d_wr = 1'($urandom_range(0, 1));
                d_rd = d_wr ? 1'($urandom_range(0, 1)) : 1'b1;
                r32 = $urandom;
                bus.tag_D_arb   = r32[TNUM-1:0];
                bus.index_D_arb = r32[31:27];
                for (int k = 0; k < 16; k++) dat[k*32 +: 32] = $urandom;
                bus.write_data_D_arb = dat;
            end else if ((d_rd || d_wr) && $urandom_range(0, 7) == 0) begin
                r32 = $urandom;
                bus.tag_D_arb = r32[TNUM-1:0];
            end
            bus.read_I_arb   = i_rd;
            bus.read_D_arb   = d_rd;
            bus.write_D_arb  = d_wr;
            bus.ready_L2_arb = ($urandom_range(0, 3) == 0);
            r32 = $urandom;
            bus.read_data_L2_arb = {16{r32}};
            rst = ($urandom_range(0, 199) == 0);
            settle();

            e_g     = !m_busy ? 2'b00 : ((m_who == 1) ? 2'b01 : 2'b10);
            e_rdy_i = m_busy && bus.ready_L2_arb && !rst && m_who == 1;
            e_rdy_d = m_busy && bus.ready_L2_arb && !rst && m_who == 2;
            chk($sformatf("rnd%0d_grant", cyc), word_t'(bus.grant), word_t'(e_g));
            chk($sformatf("rnd%0d_read", cyc), word_t'(bus.read_arb_L2), word_t'(m_busy && !m_wr));
            chk($sformatf("rnd%0d_write", cyc), word_t'(bus.write_arb_L2), word_t'(m_busy && m_wr));
            chk($sformatf("rnd%0d_rdyI", cyc), word_t'(bus.ready_arb_I), word_t'(e_rdy_i));
            chk($sformatf("rnd%0d_rdyD", cyc), word_t'(bus.ready_arb_D), word_t'(e_rdy_d));
            if (m_busy) begin
                chk($sformatf("rnd%0d_tag", cyc), word_t'(bus.tag_arb_L2), word_t'(m_tag));
                chk($sformatf("rnd%0d_idx", cyc), word_t'(bus.index_arb_L2), word_t'(m_idx));
            end
            if (m_busy && m_wr) begin
                chk($sformatf("rnd%0d_wdata", cyc), bus.write_data_arb_L2, m_wdata);
            end
            if (e_rdy_i) begin
                chk($sformatf("rnd%0d_dataI", cyc), bus.read_data_arb_I, {16{r32}});
            end
            if (e_rdy_d) begin
                chk($sformatf("rnd%0d_dataD", cyc), bus.read_data_arb_D, {16{r32}});
            end

            // what the next clock edge does, stated as transaction rules
            if (rst) begin
                m_busy = 1'b0;
                m_cool = 1'b0;
                m_last = 2;
            end else if (m_busy) begin
                if (bus.ready_L2_arb) begin
                    m_busy = 1'b0;
                    m_cool = 1'b1;
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (i_rd || d_rd || d_wr) begin
                m_who  = (i_rd && (d_rd || d_wr)) ? ((m_last == 1) ? 2 : 1) : (i_rd ? 1 : 2);
                m_last = m_who;
                m_busy = 1'b1;
                if (m_who == 2) begin
                    m_wr    = d_wr;
                    m_tag   = bus.tag_D_arb;
                    m_idx   = bus.index_D_arb;
                    m_wdata = bus.write_data_D_arb;
                end else begin
                    m_wr  = 1'b0;
                    m_tag = bus.tag_I_arb;
                    m_idx = bus.index_I_arb;
                end
            end
            tick();
            if (e_rdy_i) i_rd = 1'b0;
            if (e_rdy_d) begin
                if (d_wr) d_wr = 1'b0;
                else d_rd = 1'b0;
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
